// File: rtl/pic_host_sequencer_if.sv
`default_nettype none
// ============================================================================
// pic_host_sequencer_if
// Groups the host-side request/status signals and the 8259 PIC bus pins
// driven by pic_host_sequencer. The master modport is the sequencer view;
// the slave modport is the view of whatever sits opposite (CPU logic + PIC).
// Revision: 1.0
// ============================================================================
interface pic_host_sequencer_if;
  // Host side
  logic       start;
  logic       init_done;
  logic       busy;
  logic       eoi_req;
  logic       mask_wr;
  logic [7:0] mask_val;
  logic [7:0] vector;
  logic       vector_valid;
  // PIC bus
  logic       chip_select;
  logic       A0;
  logic       write_flag;
  logic       read_flag;
  logic       INTA;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;
  logic       INT_Flag;

  modport master (
    input  start, eoi_req, mask_wr, mask_val, data_in, INT_Flag,
    output init_done, busy, vector, vector_valid,
    output chip_select, A0, write_flag, read_flag, INTA, data_out, data_oe
  );

  modport slave (
    output start, eoi_req, mask_wr, mask_val, data_in, INT_Flag,
    input  init_done, busy, vector, vector_valid,
    input  chip_select, A0, write_flag, read_flag, INTA, data_out, data_oe
  );
endinterface
`default_nettype wire

// File: rtl/pic_host_sequencer.sv
`default_nettype none
// ============================================================================
// pic_host_sequencer
// Clocked host-side master for the 8259 PIC bus. On start it writes ICW1,
// ICW2, optional ICW3, optional ICW4 and OCW1 back to back; afterwards it
// arbitrates INTA service > EOI (OCW2 0x20) > runtime mask (OCW1) writes.
// All bus outputs are registered, decoded from the next FSM state.
// Optional feature macro: PIC_SEQ_AEOI_EN -- auto-EOI: ICW4 gets bit1 set,
// eoi_req is ignored and no OCW2 is ever issued.
// Revision: 1.0
// ============================================================================
module pic_host_sequencer #(
  parameter logic [7:0] ICW1_VAL   = 8'h13,
  parameter logic [7:0] ICW2_VAL   = 8'h08,
  parameter logic [7:0] ICW3_VAL   = 8'h00,
  parameter logic [7:0] ICW4_VAL   = 8'h01,
  parameter logic [7:0] OCW1_VAL   = 8'h00,
  parameter int         STROBE_CYC = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  pic_host_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_W_SETUP  = 4'd1,
    S_W_STROBE = 4'd2,
    S_W_HOLD   = 4'd3,
    S_W_RECOV  = 4'd4,
    S_I_P1     = 4'd5,
    S_I_GAP    = 4'd6,
    S_I_P2     = 4'd7,
    S_I_REL    = 4'd8,
    S_I_RECOV  = 4'd9
  } state_t;

  localparam logic [2:0] c_STEP_ICW1 = 3'd0;
  localparam logic [2:0] c_STEP_ICW2 = 3'd1;
  localparam logic [2:0] c_STEP_ICW3 = 3'd2;
  localparam logic [2:0] c_STEP_ICW4 = 3'd3;
  localparam logic [2:0] c_STEP_OCW1 = 3'd4;

  localparam logic [7:0] c_EOI_CMD     = 8'h20;
  localparam logic [3:0] c_STROBE_LAST = 4'(STROBE_CYC - 1);
  localparam logic       c_SNGL        = ICW1_VAL[1];
  localparam logic       c_IC4         = ICW1_VAL[0];

  logic w_eoi_req;

`ifdef PIC_SEQ_AEOI_EN
  localparam logic [7:0] c_ICW4_BYTE = ICW4_VAL | 8'h02;
  assign w_eoi_req = 1'b0;
`else
  localparam logic [7:0] c_ICW4_BYTE = ICW4_VAL;
  logic r_init_done;
  assign w_eoi_req = bus.eoi_req & r_init_done;
`endif

`ifdef PIC_SEQ_AEOI_EN
  logic r_init_done;
`endif

  // Init step that follows s, skipping ICW3 in single mode and ICW4 without IC4
  function automatic logic [2:0] f_next_step(input logic [2:0] s);
    case (s)
      c_STEP_ICW1: f_next_step = c_STEP_ICW2;
      c_STEP_ICW2: f_next_step = !c_SNGL ? c_STEP_ICW3 :
                                 (c_IC4 ? c_STEP_ICW4 : c_STEP_OCW1);
      c_STEP_ICW3: f_next_step = c_IC4 ? c_STEP_ICW4 : c_STEP_OCW1;
      default:     f_next_step = c_STEP_OCW1;
    endcase
  endfunction

  function automatic logic [7:0] f_step_byte(input logic [2:0] s);
    case (s)
      c_STEP_ICW1: f_step_byte = ICW1_VAL;
      c_STEP_ICW2: f_step_byte = ICW2_VAL;
      c_STEP_ICW3: f_step_byte = ICW3_VAL;
      c_STEP_ICW4: f_step_byte = c_ICW4_BYTE;
      default:     f_step_byte = OCW1_VAL;
    endcase
  endfunction

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_step, w_step_nxt;
  logic       r_in_init, w_in_init_nxt;
  logic       r_job_a0, w_job_a0_nxt;
  logic [7:0] r_job_data, w_job_data_nxt;
  logic       r_init_req;
  logic [2:0] r_eoi_cnt;
  logic       r_mask_pend;
  logic [7:0] r_mask_reg;

  logic       w_init_grant, w_eoi_grant, w_mask_grant, w_init_fin, w_vec_cap;
  logic       w_start_ok, w_mask_wr, w_int_req;
  logic [2:0] w_step_after;

  logic       r_cs_n, r_a0, r_wr_n, r_inta_n, r_oe, r_busy, r_vvalid;
  logic [7:0] r_dout, r_vector;
  logic       w_in_write;

  // A start is honoured only when no init is pending or running
  assign w_start_ok   = bus.start & ~r_in_init & ~r_init_req;
  assign w_mask_wr    = bus.mask_wr & r_init_done;
  assign w_int_req    = bus.INT_Flag & r_init_done;
  assign w_step_after = f_next_step(r_step);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, job selection and arbitration
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_step_nxt     = r_step;
    w_in_init_nxt  = r_in_init;
    w_job_a0_nxt   = r_job_a0;
    w_job_data_nxt = r_job_data;
    w_init_grant   = 1'b0;
    w_eoi_grant    = 1'b0;
    w_mask_grant   = 1'b0;
    w_init_fin     = 1'b0;
    w_vec_cap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_init_req) begin
          w_init_grant   = 1'b1;
          w_in_init_nxt  = 1'b1;
          w_step_nxt     = c_STEP_ICW1;
          w_job_a0_nxt   = 1'b0;
          w_job_data_nxt = ICW1_VAL;
          w_state_nxt    = S_W_SETUP;
        end else if (w_int_req) begin
          w_cnt_nxt   = c_STROBE_LAST;
          w_state_nxt = S_I_P1;
        end else if (r_init_done && (r_eoi_cnt != 3'd0)) begin
          w_eoi_grant    = 1'b1;
          w_job_a0_nxt   = 1'b0;
          w_job_data_nxt = c_EOI_CMD;
          w_state_nxt    = S_W_SETUP;
        end else if (r_init_done && r_mask_pend) begin
          w_mask_grant   = 1'b1;
          w_job_a0_nxt   = 1'b1;
          w_job_data_nxt = r_mask_reg;
          w_state_nxt    = S_W_SETUP;
        end
      end
      S_W_SETUP: begin
        w_cnt_nxt   = c_STROBE_LAST;
        w_state_nxt = S_W_STROBE;
      end
      S_W_STROBE: begin
        if (r_cnt == 4'd0) w_state_nxt = S_W_HOLD;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_W_HOLD: begin
        w_state_nxt = S_W_RECOV;
        w_init_fin  = r_in_init & (r_step == c_STEP_OCW1);
      end
      S_W_RECOV: begin
        // Init writes chain directly so nothing can be granted mid-init
        if (r_in_init && (r_step != c_STEP_OCW1)) begin
          w_step_nxt     = w_step_after;
          w_job_a0_nxt   = 1'b1;
          w_job_data_nxt = f_step_byte(w_step_after);
          w_state_nxt    = S_W_SETUP;
        end else begin
          w_in_init_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      S_I_P1: begin
        if (r_cnt == 4'd0) w_state_nxt = S_I_GAP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_I_GAP: begin
        w_cnt_nxt   = c_STROBE_LAST;
        w_state_nxt = S_I_P2;
      end
      S_I_P2: begin
        if (r_cnt == 4'd0) begin
          w_vec_cap   = 1'b1;
          w_state_nxt = S_I_REL;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_I_REL:   w_state_nxt = S_I_RECOV;
      S_I_RECOV: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Sequencing registers: strobe counter, init step and the latched job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 4'd0;
      r_step     <= c_STEP_ICW1;
      r_in_init  <= 1'b0;
      r_job_a0   <= 1'b0;
      r_job_data <= 8'h00;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_step     <= w_step_nxt;
      r_in_init  <= w_in_init_nxt;
      r_job_a0   <= w_job_a0_nxt;
      r_job_data <= w_job_data_nxt;
    end
  end

  // Pending requests; a request in its own grant clock survives the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_req  <= 1'b0;
      r_init_done <= 1'b0;
      r_eoi_cnt   <= 3'd0;
      r_mask_pend <= 1'b0;
      r_mask_reg  <= 8'h00;
    end else begin
      if (w_start_ok)        r_init_req <= 1'b1;
      else if (w_init_grant) r_init_req <= 1'b0;

      if (w_start_ok)      r_init_done <= 1'b0;
      else if (w_init_fin) r_init_done <= 1'b1;

      if (w_start_ok) begin
        r_eoi_cnt <= 3'd0;
      end else if (w_eoi_req && !w_eoi_grant) begin
        if (r_eoi_cnt != 3'd7) r_eoi_cnt <= r_eoi_cnt + 3'd1;
      end else if (!w_eoi_req && w_eoi_grant) begin
        r_eoi_cnt <= r_eoi_cnt - 3'd1;
      end

      if (w_start_ok) begin
        r_mask_pend <= 1'b0;
      end else if (w_mask_wr) begin
        r_mask_pend <= 1'b1;
        r_mask_reg  <= bus.mask_val;
      end else if (w_mask_grant) begin
        r_mask_pend <= 1'b0;
      end
    end
  end

  assign w_in_write = (w_state_nxt == S_W_SETUP) || (w_state_nxt == S_W_STROBE) ||
                      (w_state_nxt == S_W_HOLD);

  // Bus outputs registered from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_inta_n <= 1'b1;
      r_a0     <= 1'b0;
      r_dout   <= 8'h00;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
      r_vvalid <= 1'b0;
      r_vector <= 8'h00;
    end else begin
      r_cs_n   <= ~w_in_write;
      r_wr_n   <= ~(w_state_nxt == S_W_STROBE);
      r_inta_n <= ~((w_state_nxt == S_I_P1) || (w_state_nxt == S_I_P2));
      r_oe     <= w_in_write;
      if (w_in_write || (w_state_nxt == S_W_RECOV)) begin
        r_a0   <= w_job_a0_nxt;
        r_dout <= w_job_data_nxt;
      end else begin
        r_a0   <= 1'b0;
        r_dout <= 8'h00;
      end
      r_busy   <= (w_state_nxt != S_IDLE);
      r_vvalid <= (w_state_nxt == S_I_REL);
      if (w_vec_cap) r_vector <= bus.data_in;
    end
  end

  assign bus.chip_select  = r_cs_n;
  assign bus.A0           = r_a0;
  assign bus.write_flag   = r_wr_n;
  assign bus.read_flag    = 1'b1;
  assign bus.INTA         = r_inta_n;
  assign bus.data_out     = r_dout;
  assign bus.data_oe      = r_oe;
  assign bus.init_done    = r_init_done;
  assign bus.busy         = r_busy;
  assign bus.vector       = r_vector;
  assign bus.vector_valid = r_vvalid;

endmodule
`default_nettype wire

// File: tb/tb_pic_host_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pic_host_sequencer
// Directed stimulus pushes expected bus events (writes and vectors) into a
// queue; a negedge monitor pops and compares each event as the DUT shows it.
// Revision: 1.0
// ============================================================================
module tb_pic_host_sequencer;
  localparam int STROBE = 2;

`ifdef PIC_SEQ_AEOI_EN
  localparam logic [7:0] EXP_ICW4 = 8'h03;
  localparam bit         AEOI     = 1'b1;
`else
  localparam logic [7:0] EXP_ICW4 = 8'h01;
  localparam bit         AEOI     = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pic_host_sequencer_if bus();

  pic_host_sequencer #(
    .ICW1_VAL(8'h13), .ICW2_VAL(8'h08), .ICW3_VAL(8'h00),
    .ICW4_VAL(8'h01), .OCW1_VAL(8'h00), .STROBE_CYC(STROBE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic       is_vec;
    logic       a0;
    logic [7:0] d;
  } ev_t;

  ev_t q[$];
  int  n_checks = 0;
  int  n_pass = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic fail_msg(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  task automatic push_wr(input logic a0, input logic [7:0] d);
    q.push_back('{is_vec: 1'b0, a0: a0, d: d});
  endtask

  task automatic push_vec(input logic [7:0] v);
    q.push_back('{is_vec: 1'b1, a0: 1'b0, d: v});
  endtask

  task automatic push_init();
    push_wr(1'b0, 8'h13);
    push_wr(1'b1, 8'h08);
    push_wr(1'b1, EXP_ICW4);
    push_wr(1'b1, 8'h00);
  endtask

  // Monitor: strobe widths, INTA shape and event order
  int  wr_low = 0, inta_low = 0;
  bit  prev_wr = 1'b1, prev_inta = 1'b1, cs_bad = 1'b0;
  ev_t m_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_low = 0; inta_low = 0; prev_wr = 1'b1; prev_inta = 1'b1; cs_bad = 1'b0;
    end else begin
      if (!bus.write_flag) wr_low++;
      if (!bus.INTA) begin
        inta_low++;
        if (!bus.chip_select) cs_bad = 1'b1;
      end
      if (bus.write_flag && !prev_wr) begin
        check_eq("wr_strobe_len", wr_low, STROBE);
        check_eq("wr_hold_cs_oe", {bus.chip_select, bus.data_oe}, 2'b01);
        if (q.size() == 0) begin
          $display("FAIL unexpected_write: got A0=%0d data=0x%02h required none", bus.A0, bus.data_out);
          n_checks++;
        end else begin
          m_e = q.pop_front();
          check_eq("wr_event", {1'b0, bus.A0, bus.data_out}, m_e);
        end
        wr_low = 0;
      end
      if (bus.INTA && !prev_inta) begin
        check_eq("inta_len", inta_low, STROBE);
        check_eq("inta_cs_high", cs_bad, 1'b0);
        inta_low = 0;
        cs_bad = 1'b0;
      end
      if (bus.vector_valid) begin
        if (q.size() == 0) fail_msg("unexpected_vector");
        else begin
          m_e = q.pop_front();
          check_eq("vector_event", {1'b1, 1'b0, bus.vector}, m_e);
        end
      end
      prev_wr = bus.write_flag;
      prev_inta = bus.INTA;
    end
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.eoi_req = 1'b1;
    @(negedge clk);
    bus.eoi_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_inta_low();
    int n;
    n = 0;
    while (bus.INTA && n < 50) begin @(negedge clk); n++; end
    if (bus.INTA) fail_msg("inta_timeout");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || bus.busy) && n < 300) begin @(negedge clk); n++; end
    if (q.size() != 0 || bus.busy) fail_msg("drain_timeout");
    repeat (10) @(negedge clk);
    check_eq("drain_idle", {bus.busy, bus.chip_select, bus.INTA}, 3'b011);
  endtask

  // Init: clock 1 is the first SETUP, init_done is high in clock 20
  task automatic time_init();
    int n;
    n = 0;
    while (bus.chip_select && n < 20) begin @(negedge clk); n++; end
    if (bus.chip_select) fail_msg("init_no_setup");
    else begin
      n = 0;
      while (!bus.init_done && n < 40) begin @(negedge clk); n++; end
      check_eq("init_done_latency", n, 19);
    end
  endtask

  initial begin
    int act;
    bus.start = 1'b0; bus.data_in = 8'h00; bus.INT_Flag = 1'b0;
    bus.eoi_req = 1'b0; bus.mask_wr = 1'b0; bus.mask_val = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_ctl", {bus.chip_select, bus.write_flag, bus.read_flag, bus.INTA, bus.A0,
                         bus.data_oe, bus.init_done, bus.busy, bus.vector_valid}, 9'b1111_00000);
    check_eq("rst_data_out", bus.data_out, 8'h00);
    check_eq("rst_vector", bus.vector, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Requests before init are neither serviced nor remembered
    bus.INT_Flag = 1'b1; bus.eoi_req = 1'b1; bus.mask_wr = 1'b1; bus.mask_val = 8'hAA;
    @(negedge clk);
    bus.eoi_req = 1'b0; bus.mask_wr = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("preinit_busy", {bus.busy, bus.chip_select}, 2'b01);
    bus.INT_Flag = 1'b0;

    // Init; the second start lands while init is pending and is ignored
    push_init();
    pulse_start();
    pulse_start();
    time_init();
    drain();
    check_eq("init_done_after_init", bus.init_done, 1'b1);

    // INTA service
    bus.data_in = 8'h08; push_vec(8'h08);
    bus.INT_Flag = 1'b1;
    wait_inta_low();
    bus.INT_Flag = 1'b0;
    drain();

    // Arbitration: all three requests in one clock
    bus.data_in = 8'h2A; push_vec(8'h2A);
    if (!AEOI) push_wr(1'b0, 8'h20);
    push_wr(1'b1, 8'hF0);
    bus.eoi_req = 1'b1; bus.mask_wr = 1'b1; bus.mask_val = 8'hF0; bus.INT_Flag = 1'b1;
    @(negedge clk);
    bus.eoi_req = 1'b0; bus.mask_wr = 1'b0;
    wait_inta_low();
    bus.INT_Flag = 1'b0;
    drain();

    // A later mask write overwrites an earlier pending one
    bus.data_in = 8'h77; push_vec(8'h77); push_wr(1'b1, 8'h3C);
    bus.INT_Flag = 1'b1;
    wait_inta_low();
    bus.INT_Flag = 1'b0;
    bus.mask_wr = 1'b1; bus.mask_val = 8'h11;
    @(negedge clk);
    bus.mask_val = 8'h3C;
    @(negedge clk);
    bus.mask_wr = 1'b0;
    drain();

    // EOI counting: three requests during an INTA job
    bus.data_in = 8'h55; push_vec(8'h55);
    if (!AEOI) begin push_wr(1'b0, 8'h20); push_wr(1'b0, 8'h20); push_wr(1'b0, 8'h20); end
    bus.INT_Flag = 1'b1;
    wait_inta_low();
    bus.INT_Flag = 1'b0;
    repeat (3) pulse_eoi();
    drain();

    // Re-init with two EOIs pending: they are dropped
    bus.data_in = 8'h66; push_vec(8'h66); push_init();
    bus.INT_Flag = 1'b1;
    wait_inta_low();
    bus.INT_Flag = 1'b0;
    pulse_eoi();
    pulse_eoi();
    pulse_start();
    check_eq("reinit_done_low", bus.init_done, 1'b0);
    drain();
    check_eq("reinit_done_high", bus.init_done, 1'b1);

    // Reset in the middle of a write strobe
    pulse_start();
    act = 0;
    while (bus.write_flag && act < 20) begin @(negedge clk); act++; end
    if (bus.write_flag) fail_msg("reset_no_strobe");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset_async_ctl", {bus.write_flag, bus.chip_select, bus.INTA, bus.data_oe}, 4'b1110);
    check_eq("reset_async_status", {bus.init_done, bus.busy}, 2'b00);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (12) begin
      @(negedge clk);
      if (!bus.chip_select || !bus.INTA || bus.busy) act++;
    end
    check_eq("post_reset_quiet", act, 0);

    check_eq("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
